// File: rtl/dkong_snd_pkg.sv
// Shared types and constants for the Donkey Kong soundboard blocks.
// Holds the WAV ROM arbiter state encoding and the default ROM geometry.
package dkong_snd_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_CAPT
    } arb_state_t;

    localparam int WAV_ROM_AW = 19;
    localparam int WAV_ROM_DW = 8;

    // Width of an index into n requesters; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dkong_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N, returned as one-hot grant, binary index and valid.
module dkong_rr_pick
    import dkong_snd_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    output logic [N-1:0]              grant,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      valid
);

    localparam int PW  = idx_width(N);
    localparam int PW1 = PW + 1;

    // One extra bit so ptr+i never overflows before the wrap compare.
    logic [PW:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + PW1'(i);
            if (pos >= PW1'(N)) begin
                pos = pos - PW1'(N);
            end
            if (!valid && req[pos[PW-1:0]]) begin
                valid             = 1'b1;
                idx               = pos[PW-1:0];
                grant[pos[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dkong_wav_rom_arbiter.sv
// Round-robin arbiter sharing the fixed-latency WAV sample ROM between voices.
// Define DKONG_WAV_ARB_PRIO_EN to give requester 0 absolute priority.
module dkong_wav_rom_arbiter
    import dkong_snd_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = WAV_ROM_AW,
    parameter int DATA_W      = WAV_ROM_DW,
    parameter int ROM_LATENCY = 2
) (
    input  logic                      W_CLK_24576M,
    input  logic                      W_RESETn,
    input  logic [NUM_REQ-1:0]        I_REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] I_ADDR,
    output logic [NUM_REQ-1:0]        O_ACK,
    output logic [NUM_REQ-1:0]        O_DVALID,
    output logic [DATA_W-1:0]         O_DATA,
    output logic [ADDR_W-1:0]         O_ROM_A,
    input  logic [DATA_W-1:0]         I_ROM_D,
    output logic                      O_BUSY
);

    localparam int PW    = idx_width(NUM_REQ);
    localparam int CNT_W = 3;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("dkong_wav_rom_arbiter: NUM_REQ must be 2..8");
    end
    if (ROM_LATENCY < 1 || ROM_LATENCY > 7) begin : g_bad_latency
        $error("dkong_wav_rom_arbiter: ROM_LATENCY must be 1..7");
    end

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      gidx_q, gidx_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] dvalid_q, dvalid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  rom_a_q, rom_a_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [PW-1:0]      pick_idx;
    logic               pick_valid;
    logic               prio_hit;
    logic [PW-1:0]      g;

    dkong_rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (I_REQ),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef DKONG_WAV_ARB_PRIO_EN
    assign prio_hit = I_REQ[0];
`else
    assign prio_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        dvalid_d = '0;
        data_d   = data_q;
        rom_a_d  = rom_a_q;
        busy_d   = busy_q;
        g        = prio_hit ? '0 : pick_idx;

        case (state_q)
            ARB_IDLE: begin
                if (prio_hit || pick_valid) begin
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        if (PW'(k) == g) begin
                            rom_a_d = I_ADDR[k*ADDR_W +: ADDR_W];
                        end
                    end
                    ack_d[g] = 1'b1;
                    gidx_d   = g;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_W'(ROM_LATENCY - 1);
                    state_d  = (ROM_LATENCY == 1) ? ARB_CAPT : ARB_WAIT;
                    // A priority grant to requester 0 leaves the rotation untouched.
                    if (!prio_hit) begin
                        ptr_d = (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                    end
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ARB_CAPT;
                end
            end
            ARB_CAPT: begin
                data_d           = I_ROM_D;
                dvalid_d[gidx_q] = 1'b1;
                busy_d           = 1'b0;
                state_d          = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            ack_q    <= '0;
            dvalid_q <= '0;
            data_q   <= '0;
            rom_a_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            dvalid_q <= dvalid_d;
            data_q   <= data_d;
            rom_a_q  <= rom_a_d;
            busy_q   <= busy_d;
        end
    end

    assign O_ACK    = ack_q;
    assign O_DVALID = dvalid_q;
    assign O_DATA   = data_q;
    assign O_ROM_A  = rom_a_q;
    assign O_BUSY   = busy_q;

endmodule
